// File: rtl/display_mode_ctrl_pkg.sv
// Shared definitions for the display/mode controller: handshake state
// encoding, the ASCII blank character and the index-width helper.
package display_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } convState_t;

    localparam logic [7:0] ASCII_BLANK = 8'h20;

    // Width of a counter/index that must hold values 0..n-1 (never below 1 bit)
    function automatic int idxWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/display_mode_ctrl_if.sv
// Converter handshake bundle: the controller (master) requests a binary to
// ASCII conversion and the converter (slave) returns the digit string.
interface display_mode_ctrl_if #(
    parameter int NUM_MODES  = 4,
    parameter int NUM_DIGITS = 6
);

    logic                    conv_start;
    logic [NUM_MODES-1:0]    conv_mode;
    logic                    conv_valid;
    logic [NUM_DIGITS*8-1:0] conv_digits;

    modport master (
        output conv_start,
        output conv_mode,
        input  conv_valid,
        input  conv_digits
    );

    modport slave (
        input  conv_start,
        input  conv_mode,
        output conv_valid,
        output conv_digits
    );

endinterface

// File: rtl/display_mode_ctrl_conv_handshake.sv
// Conversion handshake for the display controller: IDLE/BUSY request FSM,
// pending-request merge, BUSY timeout and the latched digit/punctuation
// registers that the LCD driver reads.
module conv_handshake
    import display_ctrl_pkg::*;
#(
    parameter int NUM_MODES    = 4,
    parameter int NUM_DIGITS   = 6,
    parameter int CONV_TIMEOUT = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_i,
    input  logic [NUM_MODES-1:0]    modeOh_i,
    input  logic                    point_i,
    input  logic                    col_i,
    display_mode_ctrl_if.master     conv,
    output logic [NUM_DIGITS*8-1:0] digits_o,
    output logic                    point_o,
    output logic                    col_o,
    output logic                    convErr_o
);

    localparam int TW = idxWidth(CONV_TIMEOUT);

    convState_t              state_q,    state_d;
    logic                    pend_q,     pend_d;
    logic [TW-1:0]           tmr_q,      tmr_d;
    logic                    start_q,    start_d;
    logic [NUM_MODES-1:0]    convMode_q, convMode_d;
    logic [NUM_DIGITS*8-1:0] digits_q,   digits_d;
    logic                    point_q,    point_d;
    logic                    col_q,      col_d;
    logic                    err_q,      err_d;

    // State register for the handshake FSM and everything it latches
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            tmr_q      <= '0;
            start_q    <= 1'b0;
            convMode_q <= '0;
            digits_q   <= '0;
            point_q    <= 1'b0;
            col_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            tmr_q      <= tmr_d;
            start_q    <= start_d;
            convMode_q <= convMode_d;
            digits_q   <= digits_d;
            point_q    <= point_d;
            col_q      <= col_d;
            err_q      <= err_d;
        end
    end

    // Next state: start on request or leftover pend, capture or time out while BUSY
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        tmr_d      = tmr_q;
        start_d    = 1'b0;
        convMode_d = convMode_q;
        digits_d   = digits_q;
        point_d    = point_q;
        col_d      = col_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_i || pend_q) begin
                    start_d    = 1'b1;
                    convMode_d = modeOh_i;
                    tmr_d      = '0;
                    pend_d     = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                pend_d = pend_q | req_i;
                if (conv.conv_valid) begin
                    digits_d = conv.conv_digits;
                    point_d  = point_i;
                    col_d    = col_i;
                    err_d    = 1'b0;
                    state_d  = IDLE;
                end else if (tmr_q == TW'(CONV_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign conv.conv_start = start_q;
    assign conv.conv_mode  = convMode_q;
    assign digits_o        = digits_q;
    assign point_o         = point_q;
    assign col_o           = col_q;
    assign convErr_o       = err_q;

endmodule

// File: rtl/display_mode_ctrl.sv
// Display/mode controller for the bike computer: mode index, one-hot mode
// indicators with overspeed blinking, blink/colon phases, conversion request
// generation and (optional) auto-return to mode 0.
// Optional feature macro: AUTO_RETURN_EN (return to mode 0 after IDLE_SECS
// seconds without a mode press).
module display_mode_ctrl
    import display_ctrl_pkg::*;
#(
    parameter int                   NUM_MODES    = 4,
    parameter int                   NUM_DIGITS   = 6,
    parameter int                   SPEED_W      = 7,
    parameter int                   SPEED_LIMIT  = 65,
    parameter logic [NUM_MODES-1:0] POINT_MASK   = 4'b0011,
    parameter logic [NUM_MODES-1:0] COL_MASK     = 4'b0100,
    parameter int                   CONV_TIMEOUT = 64,
    parameter int                   IDLE_SECS    = 30
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    mode,
    input  logic                    half_sec_pulse,
    input  logic                    sec_pulse,
    input  logic [SPEED_W-1:0]      speed,
    display_mode_ctrl_if.master     conv,
    output logic [NUM_MODES-1:0]    mode_ind,
    output logic [NUM_DIGITS*8-1:0] digits,
    output logic                    point,
    output logic                    col,
    output logic                    conv_err
);

    localparam int IW = idxWidth(NUM_MODES);

    logic [IW-1:0]        modeIdx_q, modeIdx_d;
    logic                 modeR_q;
    logic                 blinkPh_q;
    logic                 colPh_q;
    logic [NUM_MODES-1:0] modeInd_q;
    logic [NUM_MODES-1:0] modeOh;
    logic                 overspeed;
    logic                 autoRet;
    logic                 req;

`ifdef AUTO_RETURN_EN
    localparam int SW = idxWidth(IDLE_SECS + 1);
    logic [SW-1:0] secCnt_q, secCnt_d;
`else
    logic unusedIdleSecs;
    assign unusedIdleSecs = (IDLE_SECS > 0);
`endif

    // One-hot decode of the current mode index
    always_comb begin
        modeOh            = '0;
        modeOh[modeIdx_q] = 1'b1;
    end

    assign overspeed = (speed > SPEED_W'(SPEED_LIMIT));

    // Next mode index; a press beats an auto-return landing in the same cycle
    always_comb begin
        modeIdx_d = modeIdx_q;
        autoRet   = 1'b0;
`ifdef AUTO_RETURN_EN
        secCnt_d = secCnt_q;
        autoRet  = !mode && (secCnt_q == SW'(IDLE_SECS)) && (modeIdx_q != '0);
        if (mode || autoRet) begin
            secCnt_d = '0;
        end else if (sec_pulse && (secCnt_q < SW'(IDLE_SECS))) begin
            secCnt_d = secCnt_q + SW'(1);
        end
`endif
        if (mode) begin
            modeIdx_d = (modeIdx_q == IW'(NUM_MODES - 1)) ? '0 : modeIdx_q + IW'(1);
        end else if (autoRet) begin
            modeIdx_d = '0;
        end
    end

`ifdef AUTO_RETURN_EN
    // Seconds since the last press, saturating at IDLE_SECS
    always_ff @(posedge clock) begin
        if (reset) begin
            secCnt_q <= '0;
        end else begin
            secCnt_q <= secCnt_d;
        end
    end
`endif

    // Mode index, delayed press pulse, blink/colon phases and indicator register
    always_ff @(posedge clock) begin
        if (reset) begin
            modeIdx_q <= '0;
            modeR_q   <= 1'b0;
            blinkPh_q <= 1'b0;
            colPh_q   <= 1'b0;
            modeInd_q <= '0;
        end else begin
            modeIdx_q <= modeIdx_d;
            modeR_q   <= mode | autoRet;
            blinkPh_q <= blinkPh_q ^ half_sec_pulse;
            colPh_q   <= colPh_q ^ sec_pulse;
            modeInd_q <= (overspeed && blinkPh_q) ? '1 : modeOh;
        end
    end

    assign req      = sec_pulse | modeR_q;
    assign mode_ind = modeInd_q;

    conv_handshake #(
        .NUM_MODES   (NUM_MODES),
        .NUM_DIGITS  (NUM_DIGITS),
        .CONV_TIMEOUT(CONV_TIMEOUT)
    ) uHandshake (
        .clock    (clock),
        .reset    (reset),
        .req_i    (req),
        .modeOh_i (modeOh),
        .point_i  (POINT_MASK[modeIdx_q]),
        .col_i    (COL_MASK[modeIdx_q] & colPh_q),
        .conv     (conv),
        .digits_o (digits),
        .point_o  (point),
        .col_o    (col),
        .convErr_o(conv_err)
    );

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Self-checking bench for display_mode_ctrl. A transaction-level reference
// model predicts every cycle's outputs and every conversion request; a
// monitor process pops those predictions and compares. Honours AUTO_RETURN_EN.
module tb_display_mode_ctrl;
    import display_ctrl_pkg::*;

    localparam int         NUM_MODES    = 4;
    localparam int         NUM_DIGITS   = 6;
    localparam int         SPEED_W      = 7;
    localparam int         SPEED_LIMIT  = 65;
    localparam int         CONV_TIMEOUT = 64;
    localparam int         IDLE_SECS    = 3;
    localparam logic [3:0] POINT_MASK   = 4'b0011;
    localparam logic [3:0] COL_MASK     = 4'b0100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mode = 1'b0;
    logic        half_sec_pulse = 1'b0;
    logic        sec_pulse = 1'b0;
    logic [6:0]  speed = '0;
    logic [3:0]  mode_ind;
    logic [47:0] digits;
    logic        point;
    logic        col;
    logic        conv_err;

    display_mode_ctrl_if #(.NUM_MODES(NUM_MODES), .NUM_DIGITS(NUM_DIGITS)) convBus ();

    display_mode_ctrl #(
        .NUM_MODES   (NUM_MODES),
        .NUM_DIGITS  (NUM_DIGITS),
        .SPEED_W     (SPEED_W),
        .SPEED_LIMIT (SPEED_LIMIT),
        .POINT_MASK  (POINT_MASK),
        .COL_MASK    (COL_MASK),
        .CONV_TIMEOUT(CONV_TIMEOUT),
        .IDLE_SECS   (IDLE_SECS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mode          (mode),
        .half_sec_pulse(half_sec_pulse),
        .sec_pulse     (sec_pulse),
        .speed         (speed),
        .conv          (convBus),
        .mode_ind      (mode_ind),
        .digits        (digits),
        .point         (point),
        .col           (col),
        .conv_err      (conv_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [3:0]  modeInd;
        logic [3:0]  convMode;
        logic [47:0] digits;
        logic        point;
        logic        col;
        logic        err;
    } status_t;

    typedef struct {
        int         cyc;
        logic [3:0] mode;
    } start_t;

    status_t expQ[$];
    start_t  startQ[$];

    int checksDone = 0;
    int checksPassed = 0;

    // Reference model state: what the display should be showing this cycle
    int          mIdx = 0;
    bit          mBlink = 0;
    bit          mColph = 0;
    bit          mPress = 0;
    bit          mBusy = 0;
    int          mBusySince = 0;
    bit          mPend = 0;
    logic [3:0]  mConvMode = '0;
    logic [47:0] mDigits = '0;
    logic        mPoint = 1'b0;
    logic        mCol = 1'b0;
    logic        mErr = 1'b0;
    logic [3:0]  mModeInd = '0;
    int          mSecs = 0;
    logic [6:0]  curSpeed = 7'd40;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checksDone++;
        if (act !== req) begin
            $display("[TB] FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end else begin
            checksPassed++;
        end
    endtask

    function automatic logic [47:0] randDigits();
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[i*8 +: 8] = ($urandom_range(0, 4) == 0) ? ASCII_BLANK : 8'(8'h30 + $urandom_range(0, 9));
        end
        return r;
    endfunction

    // Advance the model by one cycle of inputs and queue its predictions for the next cycle
    task automatic modelStep(input bit rst, input bit m, input bit h, input bit s,
                             input logic [6:0] sp, input bit v, input logic [47:0] d);
        bit req;
        bit ret;
        bit startNow;
        startNow = 0;
        if (rst) begin
            mIdx = 0; mBlink = 0; mColph = 0; mPress = 0; mBusy = 0; mBusySince = 0;
            mPend = 0; mConvMode = '0; mDigits = '0; mPoint = 0; mCol = 0; mErr = 0;
            mModeInd = '0; mSecs = 0;
        end else begin
            req = s || mPress;
`ifdef AUTO_RETURN_EN
            ret = !m && (mSecs >= IDLE_SECS) && (mIdx != 0);
`else
            ret = 0;
`endif
            if (!mBusy) begin
                if (req || mPend) begin
                    startNow   = 1;
                    mConvMode  = 4'(1 << mIdx);
                    mBusy      = 1;
                    mBusySince = cyc + 1;
                    mPend      = 0;
                end
            end else begin
                mPend = mPend || req;
                if (v) begin
                    mDigits = d;
                    mPoint  = POINT_MASK[mIdx];
                    mCol    = COL_MASK[mIdx] & mColph;
                    mErr    = 0;
                    mBusy   = 0;
                end else if (cyc - mBusySince >= CONV_TIMEOUT - 1) begin
                    mErr  = 1;
                    mBusy = 0;
                end
            end
            mModeInd = ((int'(sp) > SPEED_LIMIT) && mBlink) ? 4'hF : 4'(1 << mIdx);
            mBlink   = mBlink ^ h;
            mColph   = mColph ^ s;
            if (m || ret) mSecs = 0;
            else if (s && mSecs < IDLE_SECS) mSecs++;
            if (m) mIdx = (mIdx + 1) % NUM_MODES;
            else if (ret) mIdx = 0;
            mPress = m || ret;
        end
        expQ.push_back('{cyc + 1, mModeInd, mConvMode, mDigits, mPoint, mCol, mErr});
        if (startNow) startQ.push_back('{cyc + 1, mConvMode});
    endtask

    // Drive one cycle of inputs, update the model, then move just past the next edge
    task automatic applyStimulus(input bit rst, input bit m, input bit h, input bit s, input bit v);
        logic [47:0] d;
        d = randDigits();
        reset               = rst;
        mode                = m;
        half_sec_pulse      = h;
        sec_pulse           = s;
        speed               = curSpeed;
        convBus.conv_valid  = v;
        convBus.conv_digits = d;
        modelStep(rst, m, h, s, curSpeed, v, d);
        @(posedge clock);
        #1;
    endtask

    // Quiet cycles; the converter answers validDelay cycles into BUSY (never if negative)
    task automatic quiet(input int n, input int validDelay, input int halfEvery);
        bit v;
        bit h;
        for (int k = 0; k < n; k++) begin
            v = (validDelay >= 0) && mBusy && (cyc - mBusySince >= validDelay);
            h = (halfEvery > 0) && (k % halfEvery == 0);
            applyStimulus(0, 0, h, 0, v);
        end
    endtask

    status_t monE;
    start_t  monS;

    // Scoreboard monitor: compare status every predicted cycle and each conv_start pulse
    always @(negedge clock) begin
        if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
            monE = expQ.pop_front();
            checkOutput("mode_ind",  64'(mode_ind),          64'(monE.modeInd));
            checkOutput("conv_mode", 64'(convBus.conv_mode), 64'(monE.convMode));
            checkOutput("digits",    64'(digits),            64'(monE.digits));
            checkOutput("point",     64'(point),             64'(monE.point));
            checkOutput("col",       64'(col),               64'(monE.col));
            checkOutput("conv_err",  64'(conv_err),          64'(monE.err));
        end
        if (convBus.conv_start === 1'b1) begin
            if (startQ.size() == 0) begin
                checkOutput("conv_start_unexpected", 64'(convBus.conv_start), 64'd0);
            end else begin
                monS = startQ.pop_front();
                checkOutput("conv_start_cycle", 64'(cyc), 64'(monS.cyc));
                checkOutput("conv_start_mode", 64'(convBus.conv_mode), 64'(monS.mode));
            end
        end else if (startQ.size() > 0 && startQ[0].cyc <= cyc) begin
            monS = startQ.pop_front();
            checkOutput("conv_start_missing", 64'(convBus.conv_start), 64'd1);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit rr;
        bit m;
        bit h;
        bit s;
        bit v;
        convBus.conv_valid  = 1'b0;
        convBus.conv_digits = '0;
        @(posedge clock);
        #1;
        $display("[TB] reset with busy inputs");
        for (int k = 0; k < 3; k++) applyStimulus(1, 1, 1, 1, 1);

        $display("[TB] five presses, wrap and two-cycle start latency");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1, 0, 0, 0);
            quiet(9, 3, 0);
        end

        $display("[TB] overspeed blinking in mode 2");
        applyStimulus(0, 1, 0, 0, 0);
        quiet(8, 3, 0);
        curSpeed = 7'd66;
        quiet(16, 3, 3);
        curSpeed = 7'd65;
        quiet(10, 3, 3);

        $display("[TB] press and second tick merge into one request");
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        quiet(12, 4, 0);

        $display("[TB] press while busy");
        applyStimulus(0, 1, 0, 0, 0);
        quiet(3, -1, 0);
        applyStimulus(0, 1, 0, 0, 0);
        quiet(2, -1, 0);
        applyStimulus(0, 0, 0, 0, 1);
        quiet(12, 3, 0);

        $display("[TB] timeout, stale result, recovery");
        applyStimulus(0, 1, 0, 0, 0);
        quiet(70, -1, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        quiet(2, -1, 0);
        applyStimulus(0, 1, 0, 0, 0);
        quiet(8, 2, 0);

        $display("[TB] idle seconds in mode 3");
        while (mIdx != 3) begin
            applyStimulus(0, 1, 0, 0, 0);
            quiet(8, 2, 0);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 1, 0);
            quiet(6, 2, 0);
        end
        quiet(12, 2, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2000; i++) begin
            curSpeed = 7'($urandom_range(60, 70));
            rr = ($urandom_range(0, 499) == 0);
            m  = ($urandom_range(0, 7) == 0);
            h  = ($urandom_range(0, 5) == 0);
            s  = ($urandom_range(0, 9) == 0);
            v  = mBusy ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 29) == 0);
            applyStimulus(rr, m, h, s, v);
        end
        quiet(80, 2, 0);
        @(negedge clock);
        #1;
        if (startQ.size() != 0) checkOutput("start_queue_drained", 64'(startQ.size()), 64'd0);
        $display("%0d/%0d checks passed", checksPassed, checksDone);
        $finish;
    end

endmodule
